// File: rtl/awgn_noise_out.sv
// Final Box-Muller stage: forms f*sin and f*cos, rounds/saturates to Q5.11 and
// streams the pair out serially (x0 then x1) on a valid/ready handshake.
module awgn_noise_out #(
    parameter int F_W = 17,
    parameter int G_W = 16,
    parameter int X_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [F_W-1:0]        f_in,
    input  logic signed [G_W-1:0] g0_in,
    input  logic signed [G_W-1:0] g1_in,
    output logic signed [X_W-1:0] noise_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sel
);

    localparam int F_FRAC = 13;
    localparam int G_FRAC = 14;
    localparam int X_FRAC = 11;
    localparam int SHIFT  = F_FRAC + G_FRAC - X_FRAC;
    localparam int PW     = F_W + 1 + G_W;

    localparam logic signed [PW:0] RND  = {{(PW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [PW:0] XMAX = {{(PW+2-X_W){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [PW:0] XMIN = {{(PW+2-X_W){1'b1}}, {(X_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_t;

    // Round half-up toward +inf, then clamp into the output range.
    function automatic logic signed [X_W-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] sum;
        logic signed [PW:0] r;
        sum = {p[PW-1], p} + RND;
        r   = sum >>> SHIFT;
        if (r > XMAX)
            round_sat = XMAX[X_W-1:0];
        else if (r < XMIN)
            round_sat = XMIN[X_W-1:0];
        else
            round_sat = r[X_W-1:0];
    endfunction

    logic                  vld_p0_q, vld_p0_d;
    logic [F_W-1:0]        f_p0_q, f_p0_d;
    logic signed [G_W-1:0] g0_p0_q, g0_p0_d;
    logic signed [G_W-1:0] g1_p0_q, g1_p0_d;
    logic                  vld_p1_q, vld_p1_d;
    logic signed [X_W-1:0] x0_p1_q, x0_p1_d;
    logic signed [X_W-1:0] x1_p1_q, x1_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic signed [X_W-1:0] x0_p2_q, x0_p2_d;
    logic signed [X_W-1:0] x1_p2_q, x1_p2_d;
    logic signed [X_W-1:0] x1_hold_q, x1_hold_d;
    logic signed [X_W-1:0] noise_out_q, noise_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sel_q, out_sel_d;
    state_t                state_q, state_d;

    logic                  out_free, pair_load, adv_p2, adv_p1, adv_p0;
    logic signed [PW-1:0]  prod0, prod1;

    always_comb begin
        out_free  = (state_q == IDLE) | ((state_q == EMIT1) & out_ready);
        pair_load = vld_p2_q & out_free;
        adv_p2    = !vld_p2_q | pair_load;
        adv_p1    = !vld_p1_q | adv_p2;
        adv_p0    = !vld_p0_q | adv_p1;

        prod0 = PW'($signed({1'b0, f_p0_q})) * PW'(g0_p0_q);
        prod1 = PW'($signed({1'b0, f_p0_q})) * PW'(g1_p0_q);

        // input capture
        vld_p0_d = vld_p0_q;
        f_p0_d   = f_p0_q;
        g0_p0_d  = g0_p0_q;
        g1_p0_d  = g1_p0_q;
        if (adv_p0) begin
            vld_p0_d = in_valid;
            if (in_valid) begin
                f_p0_d  = f_in;
                g0_p0_d = g0_in;
                g1_p0_d = g1_in;
            end
        end

        // rounded / saturated products
        vld_p1_d = vld_p1_q;
        x0_p1_d  = x0_p1_q;
        x1_p1_d  = x1_p1_q;
        if (adv_p1) begin
            vld_p1_d = vld_p0_q;
            if (vld_p0_q) begin
                x0_p1_d = round_sat(prod0);
                x1_p1_d = round_sat(prod1);
            end
        end

        // pair buffer
        vld_p2_d = vld_p2_q;
        x0_p2_d  = x0_p2_q;
        x1_p2_d  = x1_p2_q;
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                x0_p2_d = x0_p1_q;
                x1_p2_d = x1_p1_q;
            end
        end

        // serialiser: the emitting pair lives in the output registers
        state_d     = state_q;
        noise_out_d = noise_out_q;
        out_sel_d   = out_sel_q;
        x1_hold_d   = x1_hold_q;
        if (pair_load) begin
            state_d     = EMIT0;
            noise_out_d = x0_p2_q;
            out_sel_d   = 1'b0;
            x1_hold_d   = x1_p2_q;
        end else if ((state_q == EMIT0) && out_ready) begin
            state_d     = EMIT1;
            noise_out_d = x1_hold_q;
            out_sel_d   = 1'b1;
        end else if ((state_q == EMIT1) && out_ready) begin
            state_d     = IDLE;
        end
        out_valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        f_p0_q    <= f_p0_d;
        g0_p0_q   <= g0_p0_d;
        g1_p0_q   <= g1_p0_d;
        x0_p1_q   <= x0_p1_d;
        x1_p1_q   <= x1_p1_d;
        x0_p2_q   <= x0_p2_d;
        x1_p2_q   <= x1_p2_d;
        x1_hold_q <= x1_hold_d;
        if (rst) begin
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            noise_out_q <= '0;
            out_sel_q   <= 1'b0;
        end else begin
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            noise_out_q <= noise_out_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign in_ready  = adv_p0;
    assign noise_out = noise_out_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule
